// File: rtl/tetris_pkg.sv
// Shared board geometry and sequencer state encoding for the falling-block datapath.
package tetris_pkg;

  localparam int COLS      = 12;
  localparam int ROWS      = 12;
  localparam int BOARD_W   = ROWS * COLS;
  localparam int ROW_IDX_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SPAWN_REQ,
    ST_SPAWN_LOAD,
    ST_FALL,
    ST_LOCK,
    ST_CLEAR,
    ST_GAMEOVER
  } state_t;

endpackage

// File: rtl/row_compactor.sv
// Combinational row remover: reports whether the indexed row is full and produces
// the board with that row deleted, rows above dropping one and a zero row on top.
module row_compactor
  import tetris_pkg::*;
(
  input  logic [BOARD_W-1:0]   board_i,
  input  logic [ROW_IDX_W-1:0] rowIdx_i,
  output logic                 rowFull_o,
  output logic [BOARD_W-1:0]   board_o
);

  logic [BOARD_W-1:0] shiftedDown;

  assign shiftedDown = board_i >> COLS;

  // Rows below the index keep their place; the index row and everything above take the row above.
  always_comb begin
    rowFull_o = 1'b0;
    board_o   = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (ROW_IDX_W'(r) == rowIdx_i) begin
        rowFull_o = &board_i[r*COLS +: COLS];
      end
      if (ROW_IDX_W'(r) < rowIdx_i) begin
        board_o[r*COLS +: COLS] = board_i[r*COLS +: COLS];
      end else begin
        board_o[r*COLS +: COLS] = shiftedDown[r*COLS +: COLS];
      end
    end
  end

endmodule

// File: rtl/piece_drop_controller.sv
// Falling-block game sequencer: spawn, gravity, lock, row clear, game over.
// Optional LINE_COUNT_EN adds a saturating lines_cleared counter output.
module piece_drop_controller
  import tetris_pkg::*;
#(
  parameter int SPAWN_ROW = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               tick,
  input  logic [BOARD_W:0]   new_shape,
  output logic               refresh,
  output logic [BOARD_W-1:0] display,
  output logic               game_over,
  output logic               piece_active
`ifdef LINE_COUNT_EN
  ,
  output logic [15:0]        lines_cleared
`endif
);

  state_t                 state_q, state_d;
  logic [BOARD_W-1:0]     board_q, board_d;
  logic [BOARD_W-1:0]     piece_q, piece_d;
  logic [ROW_IDX_W-1:0]   rowIdx_q, rowIdx_d;
  logic [BOARD_W-1:0]     display_q;
  logic [BOARD_W-1:0]     spawnPiece;
  logic [BOARD_W-1:0]     compacted;
  logic                   rowFull;
  logic                   blocked;
  logic                   unused_shape_msb;

  assign unused_shape_msb = new_shape[BOARD_W];
  assign spawnPiece       = new_shape[BOARD_W-1:0] << (SPAWN_ROW * COLS);
  assign blocked          = (|piece_q[COLS-1:0]) || (|((piece_q >> COLS) & board_q));

  row_compactor u_compactor (
    .board_i  (board_q),
    .rowIdx_i (rowIdx_q),
    .rowFull_o(rowFull),
    .board_o  (compacted)
  );

  always_comb begin
    state_d  = state_q;
    board_d  = board_q;
    piece_d  = piece_q;
    rowIdx_d = rowIdx_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_SPAWN_REQ;
      end
      ST_SPAWN_REQ: state_d = ST_SPAWN_LOAD;
      // A spawn that collides with the stack ends the game without touching the board.
      ST_SPAWN_LOAD: begin
        if (|(spawnPiece & board_q)) begin
          state_d = ST_GAMEOVER;
        end else begin
          piece_d = spawnPiece;
          state_d = ST_FALL;
        end
      end
      ST_FALL: begin
        if (tick) begin
          if (blocked) state_d = ST_LOCK;
          else         piece_d = piece_q >> COLS;
        end
      end
      ST_LOCK: begin
        board_d  = board_q | piece_q;
        piece_d  = '0;
        rowIdx_d = '0;
        state_d  = ST_CLEAR;
      end
      // The index is held after a removal so the row that slid into place is rechecked.
      ST_CLEAR: begin
        if (rowIdx_q == ROW_IDX_W'(ROWS)) begin
          state_d = ST_SPAWN_REQ;
        end else if (rowFull) begin
          board_d = compacted;
        end else begin
          rowIdx_d = rowIdx_q + ROW_IDX_W'(1);
        end
      end
      ST_GAMEOVER: begin
        if (start) begin
          board_d = '0;
          state_d = ST_SPAWN_REQ;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      board_q   <= '0;
      piece_q   <= '0;
      rowIdx_q  <= '0;
      display_q <= '0;
    end else begin
      state_q   <= state_d;
      board_q   <= board_d;
      piece_q   <= piece_d;
      rowIdx_q  <= rowIdx_d;
      display_q <= board_q | piece_q;
    end
  end

  assign refresh      = (state_q == ST_SPAWN_REQ);
  assign game_over    = (state_q == ST_GAMEOVER);
  assign piece_active = (state_q == ST_FALL);
  assign display      = display_q;

`ifdef LINE_COUNT_EN
  logic [15:0] lines_q;
  logic        removeRow;
  logic        restart;

  assign removeRow = (state_q == ST_CLEAR) && (rowIdx_q != ROW_IDX_W'(ROWS)) && rowFull;
  assign restart   = (state_q == ST_GAMEOVER) && start;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lines_q <= '0;
    end else if (restart) begin
      lines_q <= '0;
    end else if (removeRow && (lines_q != 16'hFFFF)) begin
      lines_q <= lines_q + 16'd1;
    end
  end

  assign lines_cleared = lines_q;
`endif

endmodule

// File: tb/tb_piece_drop_controller.sv
// Directed bench for piece_drop_controller: a per-cycle vector table, then drop/clear/game-over sequences.
// Checks lines_cleared too when LINE_COUNT_EN is defined.
module tb_piece_drop_controller;
  import tetris_pkg::*;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               start;
  logic               tick;
  logic [BOARD_W:0]   new_shape;
  logic               refresh;
  logic [BOARD_W-1:0] display;
  logic               game_over;
  logic               piece_active;
`ifdef LINE_COUNT_EN
  logic [15:0]        lines_cleared;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic               rstN;
    logic               startIn;
    logic               tickIn;
    logic               expRefresh;
    logic               expActive;
    logic               expOver;
    logic [BOARD_W-1:0] expDisplay;
  } vec_t;

  vec_t vecs[$];

  piece_drop_controller dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .tick        (tick),
    .new_shape   (new_shape),
    .refresh     (refresh),
    .display     (display),
    .game_over   (game_over),
    .piece_active(piece_active)
`ifdef LINE_COUNT_EN
    ,
    .lines_cleared(lines_cleared)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // T-shape (row 1 = 0x020, row 0 = 0x070) with its row 0 at board row r.
  function automatic logic [BOARD_W-1:0] pieceAt(input int r);
    logic [BOARD_W-1:0] base;
    base = 144'h020070;
    return base << (r * COLS);
  endfunction

  function automatic vec_t mk(input logic r, input logic s, input logic t,
                              input logic er, input logic ea, input logic eo,
                              input logic [BOARD_W-1:0] ed);
    vec_t v;
    v.rstN = r; v.startIn = s; v.tickIn = t;
    v.expRefresh = er; v.expActive = ea; v.expOver = eo; v.expDisplay = ed;
    return v;
  endfunction

  task automatic applyStimulus(input logic r, input logic s, input logic t);
    reset_n = r;
    start   = s;
    tick    = t;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [BOARD_W-1:0] actual,
                             input logic [BOARD_W-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h required %h", name, actual, expected);
    end
  endtask

  task automatic startGame(input string name);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput({name, " refresh"}, BOARD_W'(refresh), BOARD_W'(1));
  endtask

  // Expects to be called while the sequencer is in its spawn request cycle.
  task automatic dropPiece(input logic [BOARD_W:0] shape, input logic [BOARD_W-1:0] expBoard,
                           input string name);
    int n;
    new_shape = shape;
    n = 0;
    while (!piece_active && n < 20) begin
      @(posedge clk); #1; n++;
    end
    checkOutput({name, " spawn"}, BOARD_W'(piece_active), BOARD_W'(1));
    tick = 1'b1;
    n = 0;
    while (piece_active && n < 30) begin
      @(posedge clk); #1; n++;
    end
    tick = 1'b0;
    checkOutput({name, " lock"}, BOARD_W'(piece_active), BOARD_W'(0));
    n = 0;
    while (!refresh && n < 40) begin
      @(posedge clk); #1; n++;
    end
    checkOutput({name, " respawn"}, BOARD_W'(refresh), BOARD_W'(1));
    checkOutput({name, " board"}, display, expBoard);
  endtask

  initial begin
    logic [BOARD_W-1:0] stack;
    logic [BOARD_W-1:0] column;
    int n;

    reset_n   = 1'b0;
    start     = 1'b0;
    tick      = 1'b0;
    new_shape = 145'h020070;
    column    = 144'h001001001001;

    // Per-cycle table: reset, spawn, reset mid-fall, full descent and lock, clear pass, ignored ticks.
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, '0));
    vecs.push_back(mk(1, 1, 0, 1, 0, 0, '0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, '0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, '0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, pieceAt(8)));
    vecs.push_back(mk(1, 0, 1, 0, 1, 0, pieceAt(8)));
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, pieceAt(7)));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, '0));
    vecs.push_back(mk(1, 1, 0, 1, 0, 0, '0));
    vecs.push_back(mk(1, 0, 1, 0, 0, 0, '0));
    vecs.push_back(mk(1, 0, 1, 0, 1, 0, '0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, pieceAt(8)));
    for (int k = 1; k <= 8; k++) vecs.push_back(mk(1, 0, 1, 0, 1, 0, pieceAt(9 - k)));
    vecs.push_back(mk(1, 0, 1, 0, 0, 0, pieceAt(0)));
    vecs.push_back(mk(1, 0, 1, 0, 0, 0, pieceAt(0)));
    for (int k = 0; k < ROWS; k++) vecs.push_back(mk(1, 0, 1, 0, 0, 0, pieceAt(0)));
    vecs.push_back(mk(1, 0, 1, 1, 0, 0, pieceAt(0)));
    vecs.push_back(mk(1, 0, 1, 0, 0, 0, pieceAt(0)));
    vecs.push_back(mk(1, 0, 1, 0, 1, 0, pieceAt(0)));
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, pieceAt(0) | pieceAt(8)));
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, pieceAt(0) | pieceAt(8)));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rstN, vecs[i].startIn, vecs[i].tickIn);
      checkOutput($sformatf("vec%0d refresh", i), BOARD_W'(refresh), BOARD_W'(vecs[i].expRefresh));
      checkOutput($sformatf("vec%0d active", i), BOARD_W'(piece_active), BOARD_W'(vecs[i].expActive));
      checkOutput($sformatf("vec%0d gameover", i), BOARD_W'(game_over), BOARD_W'(vecs[i].expOver));
      checkOutput($sformatf("vec%0d display", i), display, vecs[i].expDisplay);
    end

    // Single full row: 0xF8F bottom row completed by a 0x070 bar, row above drops into row 0.
    applyStimulus(0, 0, 0);
    applyStimulus(1, 0, 0);
`ifdef LINE_COUNT_EN
    checkOutput("lines after reset", BOARD_W'(lines_cleared), BOARD_W'(0));
`endif
    startGame("row clear start");
    dropPiece(145'h001F8F, 144'h001F8F, "base drop");
    dropPiece(145'h070, 144'h001, "completing drop");
`ifdef LINE_COUNT_EN
    checkOutput("lines after one", BOARD_W'(lines_cleared), BOARD_W'(1));
`endif

    // Two adjacent full rows formed at rows 0 and 1, with 0x123 above them ending at row 0.
    dropPiece(145'h123FFFFFE, 144'h123, "double clear");
`ifdef LINE_COUNT_EN
    checkOutput("lines after three", BOARD_W'(lines_cleared), BOARD_W'(3));
`endif

    // Stack single-cell columns until the spawn region collides.
    dropPiece({1'b0, column}, (column << COLS) | 144'h123, "column one");
    stack = (column << (5 * COLS)) | (column << COLS) | 144'h123;
    dropPiece({1'b0, column}, stack, "column two");
    new_shape = {1'b0, column};
    n = 0;
    while (!game_over && n < 10) begin
      @(posedge clk); #1; n++;
    end
    checkOutput("gameover flag", BOARD_W'(game_over), BOARD_W'(1));
    checkOutput("gameover active", BOARD_W'(piece_active), BOARD_W'(0));
    checkOutput("gameover board", display, stack);
    for (int k = 0; k < 3; k++) applyStimulus(1, 0, 1);
    tick = 1'b0;
    checkOutput("gameover tick ignored", display, stack);
    checkOutput("gameover held", BOARD_W'(game_over), BOARD_W'(1));
    applyStimulus(1, 1, 0);
    start = 1'b0;
    checkOutput("restart refresh", BOARD_W'(refresh), BOARD_W'(1));
    checkOutput("restart gameover", BOARD_W'(game_over), BOARD_W'(0));
`ifdef LINE_COUNT_EN
    checkOutput("restart lines", BOARD_W'(lines_cleared), BOARD_W'(0));
`endif
    applyStimulus(1, 0, 0);
    checkOutput("restart display", display, '0);
    checkOutput("restart refresh once", BOARD_W'(refresh), BOARD_W'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
